mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit that owns the HI/LO registers.
// Multiply uses shift-add and divide uses restoring subtraction, one bit per clock.
// Signed operands are reduced to magnitudes on entry. The sign is fixed in a
// single cycle at the end.
// Build option: define MDU_DIV_EN to include the divide datapath. Without it,
// DIV/DIVU are ignored in the same way as the reserved opcodes.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write HI/LO here
// RUN   | WIDTH iterations, one product/quotient bit per cycle
// FIX   | sign correction, HI/LO write, done pulse
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

  stateT             state;
  logic [CntW-1:0]   bitCnt;
  logic [WIDTH-1:0]  operandB;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  accHi;      // upper partial product / partial remainder
  logic [WIDTH-1:0]  accLo;      // multiplier bits / dividend-then-quotient bits
  logic              negLo;      // negate the product (mul) or the quotient (div)
`ifdef MDU_DIV_EN
  logic              negHi;      // negate the remainder
  logic              isDiv;
  logic              opDiv;
  logic [WIDTH:0]    remShift;
  logic [WIDTH:0]    remDiff;
  logic [WIDTH-1:0]  divHiNext;
  logic [WIDTH-1:0]  divLoNext;
`endif

  logic              opIter;
  logic              opSigned;
  logic              aNeg;
  logic              bNeg;
  logic [WIDTH-1:0]  aMag;
  logic [WIDTH-1:0]  bMag;
  logic              negLoStart;
  logic [WIDTH:0]    mulSum;
  logic [WIDTH-1:0]  mulHiNext;
  logic [WIDTH-1:0]  mulLoNext;
  logic [WIDTH-1:0]  stepHi;
  logic [WIDTH-1:0]  stepLo;
  logic [2*WIDTH-1:0] prodRaw;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]  resHi;
  logic [WIDTH-1:0]  resLo;

  // Decode the request and form operand magnitudes and result signs.
  always_comb begin
    opIter   = 1'b0;
    opSigned = 1'b0;
`ifdef MDU_DIV_EN
    opDiv    = 1'b0;
`endif
    case (op)
      OpMult:  begin opIter = 1'b1; opSigned = 1'b1; end
      OpMultu: begin opIter = 1'b1; end
`ifdef MDU_DIV_EN
      OpDiv:   begin opIter = 1'b1; opSigned = 1'b1; opDiv = 1'b1; end
      OpDivu:  begin opIter = 1'b1; opDiv = 1'b1; end
`endif
      default: ;
    endcase
    aNeg = opSigned & a[WIDTH-1];
    bNeg = opSigned & b[WIDTH-1];
    aMag = aNeg ? -a : a;
    bMag = bNeg ? -b : b;
`ifdef MDU_DIV_EN
    // A zero divisor must leave the quotient as all ones, so it is never negated.
    negLoStart = (aNeg ^ bNeg) & ~(opDiv & (b == '0));
`else
    negLoStart = aNeg ^ bNeg;
`endif
  end

  // Compute one iteration step and the sign-corrected final result.
  always_comb begin
    mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, operandB} : {(WIDTH+1){1'b0}});
    mulHiNext = mulSum[WIDTH:1];
    mulLoNext = {mulSum[0], accLo[WIDTH-1:1]};
    stepHi    = mulHiNext;
    stepLo    = mulLoNext;
    prodRaw   = {accHi, accLo};
    prodFix   = negLo ? -prodRaw : prodRaw;
    resHi     = prodFix[2*WIDTH-1:WIDTH];
    resLo     = prodFix[WIDTH-1:0];
`ifdef MDU_DIV_EN
    remShift  = {accHi, accLo[WIDTH-1]};
    remDiff   = remShift - {1'b0, operandB};
    if (!remDiff[WIDTH]) begin
      divHiNext = remDiff[WIDTH-1:0];
      divLoNext = {accLo[WIDTH-2:0], 1'b1};
    end else begin
      divHiNext = remShift[WIDTH-1:0];
      divLoNext = {accLo[WIDTH-2:0], 1'b0};
    end
    if (isDiv) begin
      stepHi = divHiNext;
      stepLo = divLoNext;
      resHi  = negHi ? -accHi : accHi;
      resLo  = negLo ? -accLo : accLo;
    end
`endif
  end

  // Sequencer FSM with registered busy/done and the HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      bitCnt   <= '0;
      operandB <= '0;
      accHi    <= '0;
      accLo    <= '0;
      negLo    <= 1'b0;
`ifdef MDU_DIV_EN
      negHi    <= 1'b0;
      isDiv    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (opIter) begin
              state    <= RUN;
              busy     <= 1'b1;
              bitCnt   <= CntW'(WIDTH-1);
              operandB <= bMag;
              accHi    <= '0;
              accLo    <= aMag;
              negLo    <= negLoStart;
`ifdef MDU_DIV_EN
              negHi    <= aNeg;
              isDiv    <= opDiv;
`endif
            end else if (op == OpMthi) begin
              hi <= a;
            end else if (op == OpMtlo) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            accHi <= stepHi;
            accLo <= stepLo;
            if (bitCnt == '0) begin
              state <= FIX;
            end else begin
              bitCnt <= bitCnt - CntW'(1);
            end
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            hi   <= resHi;
            lo   <= resLo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
